// File: rtl/cell_builder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cell_builder: packs a raster pixel stream into an 8-line cell cache and  |
// | hands each complete frame to the downstream cell fetcher.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cell_builder #(
  parameter int PIXEL_W        = 12,
  parameter int FRAME_COL_CNUM = 40,
  parameter int FRAME_ROW_CNUM = 30,
  parameter int CELL_NUM       = FRAME_COL_CNUM * FRAME_ROW_CNUM,
  parameter int CELL_ADDR_W    = $clog2(CELL_NUM),
  parameter int BEAT_W         = 8 * PIXEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BEAT_W-1:0]      pix_data_i,
  input  logic                   pix_sof_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  output logic                   cache_wr_en_o,
  output logic [CELL_ADDR_W-1:0] cache_wr_addr_o,
  output logic [2:0]             cache_wr_line_o,
  output logic [BEAT_W-1:0]      cache_wr_data_o,
  output logic                   cell_fetch_start_o,
  input  logic                   cell_fetch_done_i,
  output logic                   frame_err_o
);

  localparam int c_COL_W  = (FRAME_COL_CNUM > 1) ? $clog2(FRAME_COL_CNUM) : 1;
  localparam int c_CROW_W = (FRAME_ROW_CNUM > 1) ? $clog2(FRAME_ROW_CNUM) : 1;

  localparam logic [c_COL_W-1:0]     c_COL_LAST  = c_COL_W'(FRAME_COL_CNUM - 1);
  localparam logic [c_CROW_W-1:0]    c_CROW_LAST = c_CROW_W'(FRAME_ROW_CNUM - 1);
  localparam logic [CELL_ADDR_W-1:0] c_ROW_STEP  = CELL_ADDR_W'(FRAME_COL_CNUM);

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_FLUSH = 2'd1;
  localparam logic [1:0] c_ST_START = 2'd2;
  localparam logic [1:0] c_ST_WAIT  = 2'd3;

  logic [1:0]             r_state;
  logic [c_COL_W-1:0]     r_col;
  logic [2:0]             r_line;
  logic [c_CROW_W-1:0]    r_crow;
  logic [CELL_ADDR_W-1:0] r_row_base;
  logic                   r_wr_en;
  logic [CELL_ADDR_W-1:0] r_wr_addr;
  logic [2:0]             r_wr_line;
  logic [BEAT_W-1:0]      r_wr_data;
  logic                   r_frame_err;

  logic                   w_accept;
  logic                   w_at_origin;
  logic                   w_resync;
  logic [c_COL_W-1:0]     w_col;
  logic [2:0]             w_line;
  logic [c_CROW_W-1:0]    w_crow;
  logic [CELL_ADDR_W-1:0] w_row_base;
  logic                   w_col_wrap;
  logic                   w_line_wrap;
  logic                   w_last_beat;

  assign pix_ready_o = (r_state == c_ST_FILL);
  assign w_accept    = pix_valid_i & pix_ready_o;
  assign w_at_origin = (r_col == '0) && (r_line == '0) && (r_crow == '0);
  assign w_resync    = w_accept & pix_sof_i & ~w_at_origin;

  // A misaligned SOF re-labels the current beat as beat 0 of a fresh frame.
  assign w_col      = w_resync ? '0 : r_col;
  assign w_line     = w_resync ? '0 : r_line;
  assign w_crow     = w_resync ? '0 : r_crow;
  assign w_row_base = w_resync ? '0 : r_row_base;

  assign w_col_wrap  = (w_col == c_COL_LAST);
  assign w_line_wrap = w_col_wrap && (w_line == 3'd7);
  assign w_last_beat = w_line_wrap && (w_crow == c_CROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_line     <= '0;
      r_crow     <= '0;
      r_row_base <= '0;
    end else if (w_accept) begin
      r_col  <= w_col_wrap ? '0 : w_col + 1'b1;
      r_line <= w_col_wrap ? w_line + 1'b1 : w_line;
      if (w_last_beat) begin
        r_crow     <= '0;
        r_row_base <= '0;
      end else if (w_line_wrap) begin
        r_crow     <= w_crow + 1'b1;
        r_row_base <= w_row_base + c_ROW_STEP;
      end else begin
        r_crow     <= w_crow;
        r_row_base <= w_row_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
    end
    if (w_accept) begin
      r_wr_addr <= w_row_base + CELL_ADDR_W'(w_col);
      r_wr_line <= w_line;
      r_wr_data <= pix_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (w_resync) begin
      r_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_FILL;
    end else begin
      case (r_state)
        c_ST_FILL:  if (w_accept && w_last_beat) r_state <= c_ST_FLUSH;
        c_ST_FLUSH: r_state <= c_ST_START;
        c_ST_START: r_state <= c_ST_WAIT;
        c_ST_WAIT:  if (cell_fetch_done_i) r_state <= c_ST_FILL;
        default:    r_state <= c_ST_FILL;
      endcase
    end
  end

  assign cache_wr_en_o      = r_wr_en;
  assign cache_wr_addr_o    = r_wr_addr;
  assign cache_wr_line_o    = r_wr_line;
  assign cache_wr_data_o    = r_wr_data;
  assign cell_fetch_start_o = (r_state == c_ST_START);
  assign frame_err_o        = r_frame_err;

endmodule
`default_nettype wire
